lsu_bus: RTL
============

LSU_BUS -- requirements
Module: lsu_bus

Interface
REQ-001 Parameter XLEN, default 64, SHALL set data width (32 or 64).
REQ-002 Parameter ADDR_W, default 64, SHALL set address width.
REQ-003 clk  in  1  sole clock; all state on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  pipeline presents memory op.
REQ-006 req_ready  out  1  LSU accepts op; high only in IDLE.
REQ-007 req_we  in  1  1=store, 0=load.
REQ-008 req_memop  in  3  funct3 encoding (lb/lh/lw/ld/lbu/lhu/lwu; sb/sh/sw/sd).
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  XLEN  store data, LSB-aligned.
REQ-011 resp_valid  out  1  one-cycle response pulse; no backpressure.
REQ-012 resp_data  out  XLEN  extended load result; 0 for stores and errors.
REQ-013 resp_err  out  1  misaligned, illegal memop or bus error.
REQ-014 mem_req_valid / mem_req_ready  out/in  1  bus request handshake.
REQ-015 mem_we  out  1; mem_addr  out  ADDR_W, aligned to XLEN/8 bytes.
REQ-016 mem_wdata  out  XLEN; mem_wstrb  out  XLEN/8  lane-shifted data and byte strobes.
REQ-017 mem_rvalid  in  1; mem_rdata  in  XLEN; mem_err  in  1  bus response (also the store acknowledge).

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, RESP.
REQ-019 IDLE: on req_valid&req_ready, latch all req_* fields; legal aligned op -> REQ, otherwise -> RESP with error flagged.
REQ-020 Misaligned: h/hu addr[0]!=0; w/wu addr[1:0]!=0; d addr[2:0]!=0.
REQ-021 Illegal: load funct3=111; store funct3[2]=1; ld/lwu/sd when XLEN=32.
REQ-022 REQ: mem_req_valid=1; mem_addr/mem_we/mem_wdata/mem_wstrb stable until mem_req_ready; handshake -> WAIT.
REQ-023 WAIT: on mem_rvalid, capture extracted data and mem_err -> RESP; mem_rvalid outside WAIT SHALL be ignored.
REQ-024 RESP: resp_valid=1 for exactly one cycle -> IDLE.
REQ-025 Minimum latency, accept edge to resp_valid: 3 cycles bus path, 1 cycle error path.
REQ-026 Store strobe = base mask (b=0x1, h=0x3, w=0xF, d=0xFF) shifted left by addr offset; wdata shifted left by offset*8.
REQ-027 Load: mem_rdata shifted right by offset*8, then sign-extended (lb/lh/lw) or zero-extended (lbu/lhu/lwu) to XLEN.
REQ-028 On any error, resp_data SHALL be 0 and resp_err SHALL be 1.
REQ-029 mem_addr SHALL be req_addr with the low log2(XLEN/8) bits cleared.

Reset
REQ-030 rst_n low SHALL immediately force IDLE; resp_valid, resp_data, resp_err, mem_req_valid, mem_we, mem_wstrb SHALL all be 0.
REQ-031 req_ready SHALL be 1 from the first cycle after reset release.
REQ-032 Reset mid-operation SHALL abandon the op with no response; a subsequent stale mem_rvalid SHALL be ignored.

Structure
REQ-033 Package lsu_pkg SHALL hold memop encodings, FSM state enum and the base-mask constants.
REQ-034 Combinational sub-module lsu_align SHALL perform lane shifting, strobe generation, extension and misalignment detection; lsu_bus holds FSM and registers.

Verification
REQ-035 XLEN=64, lb addr 0x80000003, mem_rdata 0x11223344_8899AABB -> resp_data 0xFFFFFFFF_FFFFFF88, resp_err=0.
REQ-036 sh addr 0x80000006, wdata 0x1234 -> mem_addr 0x80000000, mem_wstrb 0xC0, mem_wdata[63:48]=0x1234.
REQ-037 lw addr 0x80000002 -> mem_req_valid never asserts; resp_valid one cycle after accept with resp_err=1, resp_data=0.
REQ-038 mem_req_ready held low 5 cycles -> mem_req_valid and mem_addr stable, req_ready=0 throughout; single resp_valid pulse follows.
REQ-039 rst_n pulsed low in WAIT, then mem_rvalid=1 -> no resp_valid; next lwu addr 0x80000004, rdata 0x80000000_00000000 -> resp_data 0x00000000_80000000.
REQ-040 ld with mem_rvalid=1, mem_err=1 -> resp_err=1, resp_data=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 memop encodings,
// access-size codes, byte-strobe base masks, FSM state type and the
// illegal-operation decoder.
package lsu_pkg;

    localparam logic [2:0] MEMOP_B  = 3'b000;
    localparam logic [2:0] MEMOP_H  = 3'b001;
    localparam logic [2:0] MEMOP_W  = 3'b010;
    localparam logic [2:0] MEMOP_D  = 3'b011;
    localparam logic [2:0] MEMOP_BU = 3'b100;
    localparam logic [2:0] MEMOP_HU = 3'b101;
    localparam logic [2:0] MEMOP_WU = 3'b110;

    // Access size lives in funct3[1:0] for both loads and stores
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    localparam logic [7:0] MASK_B = 8'h01;
    localparam logic [7:0] MASK_H = 8'h03;
    localparam logic [7:0] MASK_W = 8'h0F;
    localparam logic [7:0] MASK_D = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Encodings with no meaning for this direction, plus 64-bit ops on a 32-bit core
    function automatic logic memop_illegal(input logic we, input logic [2:0] memop, input int xlen);
        if (we)
            return memop[2] || (xlen == 32 && memop[1:0] == SIZE_D);
        return (memop == 3'b111) || (xlen == 32 && (memop == MEMOP_D || memop == MEMOP_WU));
    endfunction

endpackage

// File: rtl/lsu_bus_if.sv
// Memory-side bus of the LSU: a valid/ready request channel and a single
// response strobe that also serves as the store acknowledge.
interface lsu_bus_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
);
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [XLEN-1:0]     mem_wdata;
    logic [XLEN/8-1:0]   mem_wstrb;
    logic                mem_rvalid;
    logic [XLEN-1:0]     mem_rdata;
    logic                mem_err;

    modport master (
        output mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_req_ready, mem_rvalid, mem_rdata, mem_err
    );

    modport slave (
        input  mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_req_ready, mem_rvalid, mem_rdata, mem_err
    );
endinterface

// File: rtl/lsu_align.sv
// Purely combinational lane logic: misalignment detection, store strobe and
// data lane shifting, and load data extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]        memop,
    input  logic [2:0]        addr_lo,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              misaligned,
    output logic [XLEN/8-1:0] wstrb,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [XLEN-1:0]   rdata_ext
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    logic [OFF_W-1:0] offset;
    logic [OFF_W+2:0] bit_sh;
    logic [7:0]       base_mask;
    logic [XLEN-1:0]  rdata_sh;

    assign offset   = addr_lo[OFF_W-1:0];
    assign bit_sh   = {offset, 3'b000};
    assign wstrb    = STRB_W'(base_mask) << offset;
    assign wdata_sh = wdata << bit_sh;
    assign rdata_sh = rdata >> bit_sh;

    // Size decode: natural-alignment check and the unshifted strobe pattern
    always_comb begin
        misaligned = 1'b0;
        base_mask  = MASK_B;
        case (memop[1:0])
            SIZE_B: begin
                misaligned = 1'b0;
                base_mask  = MASK_B;
            end
            SIZE_H: begin
                misaligned = addr_lo[0];
                base_mask  = MASK_H;
            end
            SIZE_W: begin
                misaligned = |addr_lo[1:0];
                base_mask  = MASK_W;
            end
            default: begin
                misaligned = |addr_lo;
                base_mask  = MASK_D;
            end
        endcase
    end

    // Load result: lane-shifted data truncated to the access size then extended
    always_comb begin
        rdata_ext = rdata_sh;
        case (memop)
            MEMOP_B:  rdata_ext = XLEN'($signed(rdata_sh[7:0]));
            MEMOP_H:  rdata_ext = XLEN'($signed(rdata_sh[15:0]));
            MEMOP_W:  rdata_ext = XLEN'($signed(rdata_sh[31:0]));
            MEMOP_BU: rdata_ext = XLEN'(rdata_sh[7:0]);
            MEMOP_HU: rdata_ext = XLEN'(rdata_sh[15:0]);
            MEMOP_WU: rdata_ext = XLEN'(rdata_sh[31:0]);
            default:  rdata_ext = rdata_sh;
        endcase
    end
endmodule

// File: rtl/lsu_bus.sv
// Load/store unit bus adapter: accepts one memory op at a time from the
// pipeline, issues a single aligned bus transaction and returns a one-cycle
// response. Misaligned or illegal ops skip the bus and report an error.
module lsu_bus
    import lsu_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_memop,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err,
    lsu_bus_if.master         mem
);
    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

    lsu_state_e        state;
    lsu_state_e        state_next;
    logic              we_q;
    logic [2:0]        memop_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic [XLEN-1:0]   resp_data_q;
    logic              resp_err_q;

    logic              accept;
    logic              op_bad;
    logic [2:0]        al_memop;
    logic [2:0]        al_addr_lo;
    logic              misaligned;
    logic [STRB_W-1:0] strb;
    logic [XLEN-1:0]   wdata_sh;
    logic [XLEN-1:0]   rdata_ext;

    // In IDLE the aligner judges the incoming op; afterwards it works on the latched op
    assign al_memop   = (state == ST_IDLE) ? req_memop     : memop_q;
    assign al_addr_lo = (state == ST_IDLE) ? req_addr[2:0] : addr_q[2:0];
    assign accept     = (state == ST_IDLE) && req_valid;
    assign op_bad     = misaligned || memop_illegal(req_we, req_memop, XLEN);

    lsu_align #(.XLEN(XLEN)) u_align (
        .memop      (al_memop),
        .addr_lo    (al_addr_lo),
        .wdata      (wdata_q),
        .rdata      (mem.mem_rdata),
        .misaligned (misaligned),
        .wstrb      (strb),
        .wdata_sh   (wdata_sh),
        .rdata_ext  (rdata_ext)
    );

    // State register; reset abandons any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // Request latch on accept, response capture from the bus or the error path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            memop_q     <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                we_q        <= req_we;
                memop_q     <= req_memop;
                addr_q      <= req_addr;
                wdata_q     <= req_wdata;
                resp_data_q <= '0;
                resp_err_q  <= op_bad;
            end
            if (state == ST_WAIT && mem.mem_rvalid) begin
                resp_err_q  <= mem.mem_err;
                resp_data_q <= (mem.mem_err || we_q) ? '0 : rdata_ext;
            end
        end
    end

    // Next-state and output decode; bus signals only qualify while in REQ
    always_comb begin
        state_next        = state;
        req_ready         = 1'b0;
        resp_valid        = 1'b0;
        resp_data         = '0;
        resp_err          = 1'b0;
        mem.mem_req_valid = 1'b0;
        mem.mem_we        = 1'b0;
        mem.mem_wstrb     = '0;
        mem.mem_addr      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        mem.mem_wdata     = wdata_sh;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    state_next = op_bad ? ST_RESP : ST_REQ;
            end
            ST_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_we        = we_q;
                mem.mem_wstrb     = we_q ? strb : '0;
                if (mem.mem_req_ready)
                    state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem.mem_rvalid)
                    state_next = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_data  = resp_data_q;
                resp_err   = resp_err_q;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule
